// File: rtl/banyan_pipe.sv
// banyan_pipe: K-stage pipelined banyan switch with per-switch round-robin conflict resolution and drop counting.
module banyan_pipe #(
  parameter int DW = 32,
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           i_valid,
  input  logic [DW-1:0]          i_data [N],
  input  logic [$clog2(N)-1:0]   i_dest [N],
  input  logic                   i_clr_cnt,
  output logic [N-1:0]           o_valid,
  output logic [DW-1:0]          o_data [N],
  output logic [$clog2(N)-1:0]   o_src [N],
  output logic                   o_drop,
  output logic [CW-1:0]          o_drop_cnt
);
  localparam int K  = $clog2(N);
  localparam int S  = N / 2;
  localparam int NC = K * S;
  localparam int PW = $clog2(NC + 1);
  localparam int SW = (CW > PW ? CW : PW) + 1;
  logic [NC-1:0] conf;
  for (genvar s = 0; s < K; s++) begin : g_stage
    logic [N-1:0]  iv, nv, v;
    logic [DW-1:0] id [N], nd [N], d [N];
    logic [K-1:0]  it [N], nt [N], t [N];
    logic [K-1:0]  isr [N], nsr [N], sr [N];
    if (s == 0) begin : g_in
      assign iv = i_valid;
      assign id = i_data;
      assign it = i_dest;
      for (genvar i = 0; i < N; i++) begin : g_src
        assign isr[i] = K'(i);
      end
    end else begin : g_link
      assign iv  = g_stage[s-1].v;
      assign id  = g_stage[s-1].d;
      assign it  = g_stage[s-1].t;
      assign isr = g_stage[s-1].sr;
    end
    for (genvar j = 0; j < S; j++) begin : g_sw
      localparam int M = K - 1 - s;
      localparam int A = ((j >> M) << (M + 1)) | (j & ((1 << M) - 1));
      localparam int B = A + (1 << M);
      logic ptr, c, ra, rb, a_lo, a_hi, b_lo, b_hi;
      assign ra = it[A][M];
      assign rb = it[B][M];
      assign c  = iv[A] & iv[B] & (ra == rb);
      assign conf[s*S+j] = c;
      // a loser is masked out; the winner keeps its natural route
      assign a_lo = iv[A] & ~ra & ~(c & ptr);
      assign a_hi = iv[A] &  ra & ~(c & ptr);
      assign b_lo = iv[B] & ~rb & ~(c & ~ptr);
      assign b_hi = iv[B] &  rb & ~(c & ~ptr);
      assign nv[A]  = a_lo | b_lo;
      assign nv[B]  = a_hi | b_hi;
      assign nd[A]  = a_lo ? id[A]  : id[B];
      assign nd[B]  = a_hi ? id[A]  : id[B];
      assign nt[A]  = a_lo ? it[A]  : it[B];
      assign nt[B]  = a_hi ? it[A]  : it[B];
      assign nsr[A] = a_lo ? isr[A] : isr[B];
      assign nsr[B] = a_hi ? isr[A] : isr[B];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= 1'b0;
        else if (c) ptr <= ~ptr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= '0;
        for (int i = 0; i < N; i++) begin
          d[i]  <= '0;
          t[i]  <= '0;
          sr[i] <= '0;
        end
      end else begin
        v <= nv;
        for (int i = 0; i < N; i++)
          if (nv[i]) begin
            d[i]  <= nd[i];
            t[i]  <= nt[i];
            sr[i] <= nsr[i];
          end
      end
    end
  end
  logic unused_t;
  always_comb begin
    unused_t = 1'b0;
    for (int i = 0; i < N; i++) unused_t = unused_t ^ (^g_stage[K-1].t[i]);
  end
  assign o_valid = g_stage[K-1].v;
  assign o_data  = g_stage[K-1].d;
  assign o_src   = g_stage[K-1].sr;
  logic [PW-1:0] pc;
  logic [SW-1:0] sum;
  always_comb begin
    pc = '0;
    for (int i = 0; i < NC; i++) pc = pc + PW'(conf[i]);
  end
  assign sum = SW'(o_drop_cnt) + SW'(pc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_drop     <= |conf;
      o_drop_cnt <= i_clr_cnt ? '0 : sum > SW'({CW{1'b1}}) ? '1 : sum[CW-1:0];
    end
  end
endmodule

// File: tb/tb_banyan_pipe.sv
// tb_banyan_pipe: wave-level reference model of the banyan pipeline checked every cycle, plus directed literal checks.
module tb_banyan_pipe;
  localparam int N = 8, K = 3, DW = 32, MAXC = 2048;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [N-1:0] vin = '0;
  logic [DW-1:0] din [N];
  logic [K-1:0] tin [N];
  logic [N-1:0] ov, ov2;
  logic [DW-1:0] od [N], od2 [N];
  logic [K-1:0] os [N], os2 [N];
  logic odrop, odrop2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  banyan_pipe #(.DW(DW), .N(N), .CW(16)) u16 (
    .clk(clk), .rst_n(rst_n), .i_valid(vin), .i_data(din), .i_dest(tin), .i_clr_cnt(clr),
    .o_valid(ov), .o_data(od), .o_src(os), .o_drop(odrop), .o_drop_cnt(cnt));
  banyan_pipe #(.DW(DW), .N(N), .CW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .i_valid(vin), .i_data(din), .i_dest(tin), .i_clr_cnt(clr),
    .o_valid(ov2), .o_data(od2), .o_src(os2), .o_drop(odrop2), .o_drop_cnt(cnt2));
  always #5 clk = ~clk;
  logic [N-1:0] ev [MAXC];
  logic [DW-1:0] ed [MAXC][N];
  logic [K-1:0] es [MAXC][N];
  int conf [MAXC];
  bit ptr [K][N];
  int m16, m2, cyc, n_chk, n_fail;
  bit edrop, pclr;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask
  // Routes one whole input wave through all stages at once; each stage still sees waves in order.
  task automatic inject();
    bit pv [N], qv [N];
    logic [DW-1:0] pd [N], qd [N];
    logic [K-1:0] pt [N], qt [N], ps [N], qs [N];
    for (int i = 0; i < N; i++) begin
      pv[i] = vin[i]; pd[i] = din[i]; pt[i] = tin[i]; ps[i] = 3'(i);
    end
    for (int s = 0; s < K; s++) begin
      int m = K - 1 - s;
      for (int i = 0; i < N; i++) qv[i] = 0;
      for (int a = 0; a < N; a++) begin
        if (((a >> m) & 1) == 0) begin
          int b = a + (1 << m);
          int da = pt[a][m] ? b : a;
          int db = pt[b][m] ? b : a;
          if (pv[a] && pv[b] && da == db) begin
            int w = ptr[s][a] ? b : a;
            qv[da] = 1; qd[da] = pd[w]; qt[da] = pt[w]; qs[da] = ps[w];
            ptr[s][a] = !ptr[s][a];
            conf[cyc+s]++;
          end else begin
            if (pv[a]) begin qv[da] = 1; qd[da] = pd[a]; qt[da] = pt[a]; qs[da] = ps[a]; end
            if (pv[b]) begin qv[db] = 1; qd[db] = pd[b]; qt[db] = pt[b]; qs[db] = ps[b]; end
          end
        end
      end
      pv = qv; pd = qd; pt = qt; ps = qs;
    end
    for (int i = 0; i < N; i++) begin
      ev[cyc+K][i] = pv[i]; ed[cyc+K][i] = pd[i]; es[cyc+K][i] = ps[i];
    end
  endtask
  task automatic compare();
    chk("o_valid", 64'(ov), 64'(ev[cyc]));
    chk("o_valid_cw2", 64'(ov2), 64'(ev[cyc]));
    for (int i = 0; i < N; i++)
      if (ev[cyc][i]) begin
        chk($sformatf("o_data[%0d]", i), 64'(od[i]), 64'(ed[cyc][i]));
        chk($sformatf("o_src[%0d]", i), 64'(os[i]), 64'(es[cyc][i]));
        chk($sformatf("o_data_cw2[%0d]", i), 64'(od2[i]), 64'(ed[cyc][i]));
      end
    chk("o_drop", 64'(odrop), 64'(edrop));
    chk("o_drop_cnt", 64'(cnt), 64'(m16));
    chk("o_drop_cnt_cw2", 64'(cnt2), 64'(m2));
  endtask
  task automatic tick();
    if (!rst_n) begin
      for (int j = cyc; j < MAXC; j++) begin ev[j] = '0; conf[j] = 0; end
      for (int s = 0; s < K; s++) for (int i = 0; i < N; i++) ptr[s][i] = 0;
      m16 = 0; m2 = 0; edrop = 0;
    end else begin
      int c = cyc > 0 ? conf[cyc-1] : 0;
      edrop = c > 0;
      if (pclr) begin m16 = 0; m2 = 0; end
      else begin
        m16 = m16 + c > 65535 ? 65535 : m16 + c;
        m2  = m2 + c > 3 ? 3 : m2 + c;
      end
      inject();
    end
    pclr = clr && rst_n;
    @(negedge clk);
    compare();
    @(posedge clk);
    #1 cyc++;
  endtask
  task automatic idle(input int n);
    vin = '0; clr = 1'b0;
    repeat (n) tick();
  endtask
  task automatic wave04();
    vin = 8'h11; tin[0] = 3'd0; tin[4] = 3'd0;
    din[0] = $urandom; din[4] = $urandom;
  endtask
  task automatic rr_check(input int want_cnt);
    wave04(); din[0] = 32'h1000_0000; din[4] = 32'h4000_0000;
    tick();
    chk("rr drop1", 64'(odrop), 64'd1);
    din[0] = 32'h1100_0000; din[4] = 32'h4400_0000;
    tick();
    chk("rr drop2", 64'(odrop), 64'd1);
    vin = '0;
    tick();
    chk("rr valid1", 64'(ov), 64'h01);
    chk("rr src1", 64'(os[0]), 64'd0);
    chk("rr data1", 64'(od[0]), 64'h1000_0000);
    tick();
    chk("rr src2", 64'(os[0]), 64'd4);
    chk("rr data2", 64'(od[0]), 64'h4400_0000);
    chk("rr cnt", 64'(cnt), 64'(want_cnt));
    idle(2);
  endtask
  initial begin
    for (int j = 0; j < MAXC; j++) begin ev[j] = '0; conf[j] = 0; end
    for (int i = 0; i < N; i++) begin din[i] = '0; tin[i] = '0; end
    cyc = 0; n_chk = 0; n_fail = 0; m16 = 0; m2 = 0; pclr = 0; edrop = 0;
    idle(2);
    chk("reset o_valid", 64'(ov), 64'd0);
    chk("reset cnt", 64'(cnt), 64'd0);
    rst_n = 1'b1;
    vin = 8'h20; tin[5] = 3'd2; din[5] = 32'hA5A5_A5A5;
    tick();
    idle(K - 1);
    chk("single valid", 64'(ov), 64'h04);
    chk("single data", 64'(od[2]), 64'hA5A5_A5A5);
    chk("single src", 64'(os[2]), 64'd5);
    chk("single cnt", 64'(cnt), 64'd0);
    idle(2);
    for (int r = 0; r < 4; r++) begin
      vin = 8'hFF;
      for (int i = 0; i < N; i++) begin tin[i] = 3'(i); din[i] = $urandom; end
      tick();
    end
    vin = '0;
    chk("ident valid", 64'(ov), 64'hFF);
    chk("ident src7", 64'(os[7]), 64'd7);
    chk("ident src3", 64'(os[3]), 64'd3);
    idle(4);
    chk("ident cnt", 64'(cnt), 64'd0);
    rr_check(2);
    wave04(); tick(); idle(4);
    clr = 1'b1; vin = '0; tick(); clr = 1'b0;
    repeat (5) begin wave04(); tick(); end
    idle(3);
    chk("sat cnt2", 64'(cnt2), 64'd3);
    chk("sat cnt16", 64'(cnt), 64'd5);
    wave04(); clr = 1'b1; tick(); clr = 1'b0; vin = '0;
    chk("clr cnt16", 64'(cnt), 64'd0);
    chk("clr cnt2", 64'(cnt2), 64'd0);
    chk("clr drop", 64'(odrop), 64'd1);
    idle(4);
    vin = 8'hFF;
    for (int i = 0; i < N; i++) begin tin[i] = 3'(i); din[i] = $urandom; end
    tick();
    rst_n = 1'b0;
    #1 chk("midflight reset valid", 64'(ov), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    idle(6);
    chk("post reset valid", 64'(ov), 64'd0);
    chk("post reset cnt", 64'(cnt), 64'd0);
    rr_check(2);
    repeat (400) begin
      vin = 8'($urandom);
      for (int i = 0; i < N; i++) begin tin[i] = 3'($urandom_range(0, 7)); din[i] = $urandom; end
      clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
